reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_pkg.sv | 32 +++
 rtl/reg_dump_reader_if.sv | 39 +++
 rtl/reg_dump_reader.sv | 148 ++++++++++++++
 tb/tb_reg_dump_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_pkg
// Description : Shared types and constants for the register-file dump reader.
//               Holds the FSM state encoding and the bus widths used by
//               reg_dump_reader and reg_dump_reader_if.
//               Optional feature macro: REG_DUMP_CHECKSUM_EN (adds ST_CHK).
// Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 5;

  // Pseudo register index tagging the trailing checksum word.
  localparam logic [IDX_W-1:0] CHK_IDX = 5'd16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_SEND = 3'd2,
    ST_DONE = 3'd3
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    ST_CHK  = 3'd4
`endif
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_reader_if
// Description : Bundle of control, register-file read and output stream
//               signals of the dump reader.
//   master modport (the reader):
//     in  : start, rd_data[31:0], out_ready
//     out : busy, done, rd_addr[3:0], out_valid, out_data[31:0],
//           out_idx[4:0], out_last
//   slave modport : the same signals seen from the requester / register
//                   file / downstream consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_dump_reader_if;
  import reg_dump_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    input  start, rd_data, out_ready,
    output busy, done, rd_addr, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    output start, rd_data, out_ready,
    input  busy, done, rd_addr, out_valid, out_data, out_idx, out_last
  );

endinterface
`default_nettype wire

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_reader
// Description : Walks register indices FIRST_REG..LAST_REG of a register
//               file, reading each through rd_addr/rd_data, and streams the
//               contents out on a valid/ready channel tagged with the index.
//               The last word carries out_last and a one-cycle done pulse
//               follows its handshake.
//   Ports     : clk  - clock (all state on posedge)
//               rst  - asynchronous active-high reset
//               bus  - reg_dump_reader_if.master (start/busy/done, register
//                      file read port, output stream)
//   Macro     : REG_DUMP_CHECKSUM_EN - append a 17th word (idx 16) holding
//               the XOR of all dumped words; it then carries out_last.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 15
) (
  input  wire logic         clk,
  input  wire logic         rst,
  reg_dump_reader_if.master bus
);

  generate
    if ((FIRST_REG < 0) || (FIRST_REG > LAST_REG) || (LAST_REG > NUM_REGS - 1)) begin : g_bad_params
      $error("reg_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 15");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              done;
  logic              handshake;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
`endif

  assign handshake     = out_valid & bus.out_ready;

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done;
  assign bus.rd_addr   = rd_addr;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_idx   = out_idx;
  assign bus.out_last  = out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          // rd_addr is left untouched here so it keeps its last value.
          if (bus.start) begin
            rd_addr <= FIRST_A;
            state   <= ST_WAIT;
`ifdef REG_DUMP_CHECKSUM_EN
            acc     <= '0;
`endif
          end
        end

        // The register file refreshes rd_data on the falling edge after
        // rd_addr changes, so one cycle here is enough to capture it.
        ST_WAIT: begin
          out_data  <= bus.rd_data;
          out_idx   <= {1'b0, rd_addr};
          out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
          acc       <= acc ^ bus.rd_data;
`else
          out_last  <= (rd_addr == LAST_A);
`endif
          state     <= ST_SEND;
        end

        ST_SEND: begin
          if (handshake) begin
            if (rd_addr != LAST_A) begin
              rd_addr   <= rd_addr + 1'b1;
              out_valid <= 1'b0;
              state     <= ST_WAIT;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              // acc already includes the word just accepted.
              out_data  <= acc;
              out_idx   <= CHK_IDX;
              out_last  <= 1'b1;
              state     <= ST_CHK;
`else
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
`endif
            end
          end
        end

`ifdef REG_DUMP_CHECKSUM_EN
        ST_CHK: begin
          if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
`endif

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_dump_reader
// Description : Directed self-checking bench for reg_dump_reader. Instance A
//               dumps registers 0..15, instance B dumps register 2 only.
//               A small register-file model drives rd_data on negedge clk.
//               Honours REG_DUMP_CHECKSUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_reader;
  import reg_dump_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_dump_reader_if a_if ();
  reg_dump_reader_if b_if ();

  reg_dump_reader #(.FIRST_REG(0), .LAST_REG(15)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.master)
  );

  reg_dump_reader #(.FIRST_REG(2), .LAST_REG(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.master)
  );

  logic [31:0] regs [NUM_REGS];

  // Register file model: read data refreshed on the falling edge.
  always @(negedge clk) begin
    a_if.rd_data <= regs[a_if.rd_addr];
    b_if.rd_data <= regs[b_if.rd_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xor_all();
    logic [31:0] x = '0;
    for (int i = 0; i < NUM_REGS; i++) x = x ^ regs[i];
    return x;
  endfunction

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int A_WORDS = 17;
  localparam int B_WORDS = 2;
`else
  localparam int A_WORDS = 16;
  localparam int B_WORDS = 1;
`endif

  // Full dump on instance A. Inputs change and outputs are sampled on negedge.
  task automatic run_a(input bit stall, input bit mid_start);
    int exp_idx     = 0;
    int words       = 0;
    int dones       = 0;
    int hs_last     = -10;
    int first_valid = -1;
    int stall_left  = stall ? 10 : 0;
    logic [31:0] exp_data;
    @(negedge clk);
    a_if.start     = 1'b1;
    a_if.out_ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cyc == 0) a_if.start = 1'b0;
      if (mid_start) begin
        if (cyc == 6 || cyc == 20) a_if.start = 1'b1;
        if (cyc == 7 || cyc == 21) a_if.start = 1'b0;
      end
      if (a_if.out_valid && first_valid < 0) first_valid = cyc;
      if (a_if.done) begin
        dones++;
        check("done_timing", cyc, hs_last + 1);
      end
      if (stall_left > 0 && a_if.out_valid && a_if.out_idx == 5'd3) begin
        a_if.out_ready = 1'b0;
        stall_left--;
        check("stall_data", a_if.out_data, 32'h0002_0100);
        check("stall_addr", a_if.rd_addr, 32'd3);
        check("stall_last", a_if.out_last, 32'd0);
      end else begin
        a_if.out_ready = 1'b1;
      end
      if (a_if.out_valid && a_if.out_ready) begin
        exp_data = (exp_idx == 16) ? xor_all() : regs[exp_idx];
        check("word_idx", a_if.out_idx, exp_idx);
        check("word_data", a_if.out_data, exp_data);
        check("word_last", a_if.out_last, (exp_idx == A_WORDS - 1) ? 32'd1 : 32'd0);
        exp_idx++;
        words++;
        hs_last = cyc;
      end
      if (dones > 0 && cyc > hs_last + 4) break;
    end
    check("first_valid_cyc", first_valid, 32'd1);
    check("word_count", words, A_WORDS);
    check("done_count", dones, 32'd1);
    check("idle_after_dump", a_if.busy, 32'd0);
    if (stall) check("stall_cycles_used", stall_left, 32'd0);
  endtask

  initial begin
    int reached;
    int saw_done;
    int saw_busy;
    int b_words;
    int b_dones;
    int b_hs;

    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h0;
    regs[1] = 32'h0001_0000;
    regs[2] = 32'h0002_0000;
    regs[3] = 32'h0002_0100;
    regs[4] = 32'h0002_0200;

    a_if.start = 1'b0; a_if.out_ready = 1'b0;
    b_if.start = 1'b0; b_if.out_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy",     a_if.busy,      32'd0);
    check("rst_valid",    a_if.out_valid, 32'd0);
    check("rst_rd_addr",  a_if.rd_addr,   32'd0);
    check("rst_out_data", a_if.out_data,  32'd0);
    check("rst_out_idx",  a_if.out_idx,   32'd0);
    check("rst_out_last", a_if.out_last,  32'd0);
    check("rst_done",     a_if.done,      32'd0);
    rst = 1'b0;

    // No dump without a start sample
    repeat (3) @(negedge clk);
    check("no_self_start", a_if.busy, 32'd0);

    // Plain full dump, then with a stall on idx 3, then with stray starts
    run_a(1'b0, 1'b0);
    check("addr_held_idle", a_if.rd_addr, 32'd15);
    run_a(1'b1, 1'b0);
    run_a(1'b0, 1'b1);

    // Abort by reset while idx 5 is presented
    @(negedge clk);
    a_if.start     = 1'b1;
    a_if.out_ready = 1'b1;
    reached = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      a_if.start = 1'b0;
      if (a_if.out_valid && a_if.out_idx == 5'd5) begin
        reached = 1;
        break;
      end
    end
    check("reach_idx5", reached, 32'd1);
    a_if.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_valid",   a_if.out_valid, 32'd0);
    check("abort_busy",    a_if.busy,      32'd0);
    check("abort_done",    a_if.done,      32'd0);
    check("abort_rd_addr", a_if.rd_addr,   32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    saw_busy = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (a_if.done) saw_done = 1;
      if (a_if.busy) saw_busy = 1;
    end
    check("abort_no_done", saw_done, 32'd0);
    check("abort_stay_idle", saw_busy, 32'd0);
    run_a(1'b0, 1'b0);

    // Single-register dump on instance B
    b_words = 0;
    b_dones = 0;
    b_hs    = -10;
    @(negedge clk);
    b_if.start     = 1'b1;
    b_if.out_ready = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      b_if.start = 1'b0;
      if (b_if.done) begin
        b_dones++;
        check("b_done_timing", cyc, b_hs + 1);
      end
      if (b_if.out_valid && b_if.out_ready) begin
        check("b_idx",  b_if.out_idx,  (b_words == 0) ? 32'd2 : 32'd16);
        check("b_data", b_if.out_data, 32'h0002_0000);
        check("b_last", b_if.out_last, (b_words == B_WORDS - 1) ? 32'd1 : 32'd0);
        b_words++;
        b_hs = cyc;
      end
      if (b_dones > 0 && cyc > b_hs + 3) break;
    end
    check("b_word_count", b_words, B_WORDS);
    check("b_done_count", b_dones, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
